// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and reset constants for the memory bus arbiter and its tag owner table.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef struct packed {
    logic valid;
    logic owner;
  } MEM_OWNER_ENTRY_t;

  localparam int MEM_ARB_NUM_TAGS     = 16;
  localparam int MEM_ARB_STARVE_LIMIT = 8;

  // mem_arb_reset constants
  localparam MEM_OWNER_ENTRY_t MEM_ARB_RESET_ENTRY  = '{valid: 1'b0, owner: 1'b0};
  localparam logic [4:0]       MEM_ARB_RESET_COUNT  = 5'd0;
  localparam logic [3:0]       MEM_ARB_RESET_STARVE = 4'd0;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Tag-indexed valid/owner storage with allocate, clear and a running count of valid entries.
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = 16,
  parameter int TAG_W    = 4,
  parameter int CNT_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_allocEn,
  input  logic [TAG_W-1:0] i_allocTag,
  input  logic             i_allocOwnerD,
  input  logic             i_clearEn,
  input  logic [TAG_W-1:0] i_clearTag,
  input  logic [TAG_W-1:0] i_lookupTag,
  output MEM_OWNER_ENTRY_t o_lookupEntry,
  output logic [CNT_W-1:0] o_count
);

  MEM_OWNER_ENTRY_t r_table [NUM_TAGS];
  logic [CNT_W-1:0] r_count;
  logic             w_inc;

  assign o_lookupEntry = r_table[i_lookupTag];
  assign o_count       = r_count;

  // Only a fresh or simultaneously-recycled entry raises the count, so it always equals the valid population.
  assign w_inc = i_allocEn &&
                 (!r_table[i_allocTag].valid || (i_clearEn && (i_clearTag == i_allocTag)));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_TAGS; k++) begin
        r_table[k] <= MEM_ARB_RESET_ENTRY;
      end
      r_count <= CNT_W'(MEM_ARB_RESET_COUNT);
    end else begin
      if (i_clearEn) begin
        r_table[i_clearTag].valid <= 1'b0;
      end
      // Allocation is written last so a same-tag return and reallocation keeps the entry valid.
      if (i_allocEn) begin
        r_table[i_allocTag] <= '{valid: 1'b1, owner: i_allocOwnerD};
      end
      r_count <= r_count + CNT_W'(w_inc) - CNT_W'(i_clearEn);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory port between Dcache and Icache and steers returns by tag owner.
// Optional Icache starvation guard enabled with `define MEM_ARB_STARVE_GUARD_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS     = MEM_ARB_NUM_TAGS,
  parameter int STARVE_LIMIT = MEM_ARB_STARVE_LIMIT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  d_proc2mem_command,
  input  logic [63:0] d_proc2mem_addr,
  input  logic [63:0] d_proc2mem_data,
  input  logic [1:0]  i_proc2mem_command,
  input  logic [63:0] i_proc2mem_addr,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [3:0]  d_mem2proc_response,
  output logic [3:0]  i_mem2proc_response,
  output logic [3:0]  d_mem2proc_tag,
  output logic [3:0]  i_mem2proc_tag,
  output logic [63:0] d_mem2proc_data,
  output logic [63:0] i_mem2proc_data,
  output logic        grant_d,
  output logic [4:0]  outstanding_cnt,
  output logic        arb_idle
);

  logic             w_dReq, w_iReq, w_forceI, w_grantD, w_grantI;
  logic             w_alloc, w_hit;
  MEM_OWNER_ENTRY_t w_entry;

  assign w_dReq = (d_proc2mem_command != BUS_NONE);
  assign w_iReq = (i_proc2mem_command != BUS_NONE);

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] r_starveCnt;

  assign w_forceI = w_iReq && (r_starveCnt == 4'(STARVE_LIMIT));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_starveCnt <= MEM_ARB_RESET_STARVE;
    end else if (w_iReq && !w_grantI) begin
      r_starveCnt <= r_starveCnt + 4'd1;
    end else begin
      r_starveCnt <= '0;
    end
  end
`else
  assign w_forceI = 1'b0;
`endif

  assign w_grantD = w_dReq && !w_forceI;
  assign w_grantI = w_iReq && !w_grantD;
  assign grant_d  = w_grantD;

  always_comb begin
    proc2mem_command    = BUS_NONE;
    proc2mem_addr       = '0;
    proc2mem_data       = '0;
    d_mem2proc_response = '0;
    i_mem2proc_response = '0;
    if (w_grantD) begin
      proc2mem_command    = d_proc2mem_command;
      proc2mem_addr       = d_proc2mem_addr;
      proc2mem_data       = d_proc2mem_data;
      d_mem2proc_response = mem2proc_response;
    end else if (w_grantI) begin
      proc2mem_command    = i_proc2mem_command;
      proc2mem_addr       = i_proc2mem_addr;
      i_mem2proc_response = mem2proc_response;
    end
  end

  assign w_alloc = (proc2mem_command == BUS_LOAD) && (mem2proc_response != 4'd0);
  assign w_hit   = (mem2proc_tag != 4'd0) && w_entry.valid;

  mem_tag_owner_table #(
    .NUM_TAGS(NUM_TAGS),
    .TAG_W   (4),
    .CNT_W   (5)
  ) u_ownerTable (
    .clock        (clock),
    .reset        (reset),
    .i_allocEn    (w_alloc),
    .i_allocTag   (mem2proc_response),
    .i_allocOwnerD(w_grantD),
    .i_clearEn    (w_hit),
    .i_clearTag   (mem2proc_tag),
    .i_lookupTag  (mem2proc_tag),
    .o_lookupEntry(w_entry),
    .o_count      (outstanding_cnt)
  );

  always_comb begin
    d_mem2proc_tag  = '0;
    i_mem2proc_tag  = '0;
    d_mem2proc_data = '0;
    i_mem2proc_data = '0;
    if (w_hit && w_entry.owner) begin
      d_mem2proc_tag  = mem2proc_tag;
      d_mem2proc_data = mem2proc_data;
    end else if (w_hit) begin
      i_mem2proc_tag  = mem2proc_tag;
      i_mem2proc_data = mem2proc_data;
    end
  end

  assign arb_idle = (outstanding_cnt == 5'd0) && !w_dReq && !w_iReq;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: per-cycle tag-table model plus directed literal checks.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clock, reset;
  logic [1:0]  dCmd, iCmd;
  logic [63:0] dAddr, dData, iAddr, memData;
  logic [3:0]  memResp, memTag;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr, proc2mem_data, d_mem2proc_data, i_mem2proc_data;
  logic [3:0]  d_mem2proc_response, i_mem2proc_response, d_mem2proc_tag, i_mem2proc_tag;
  logic        grant_d, arb_idle;
  logic [4:0]  outstanding_cnt;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 0;

  // Model: which tags are outstanding, who owns them, and how long the Icache has been waiting.
  bit mValid  [16];
  bit mOwnerD [16];
  int mWait = 0;

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .d_proc2mem_command(dCmd), .d_proc2mem_addr(dAddr), .d_proc2mem_data(dData),
    .i_proc2mem_command(iCmd), .i_proc2mem_addr(iAddr),
    .mem2proc_response(memResp), .mem2proc_data(memData), .mem2proc_tag(memTag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .d_mem2proc_response(d_mem2proc_response), .i_mem2proc_response(i_mem2proc_response),
    .d_mem2proc_tag(d_mem2proc_tag), .i_mem2proc_tag(i_mem2proc_tag),
    .d_mem2proc_data(d_mem2proc_data), .i_mem2proc_data(i_mem2proc_data),
    .grant_d(grant_d), .outstanding_cnt(outstanding_cnt), .arb_idle(arb_idle)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] dc, input logic [63:0] da, input logic [63:0] dd,
                               input logic [1:0] ic, input logic [63:0] ia,
                               input logic [3:0] rsp, input logic [3:0] tg,
                               input logic [63:0] md);
    @(posedge clock);
    #1;
    reset   = 0;
    dCmd    = dc;  dAddr = da;  dData   = dd;
    iCmd    = ic;  iAddr = ia;
    memResp = rsp; memTag = tg; memData = md;
  endtask

  // Compare against the model on every falling edge, then advance the model by one cycle.
  always @(negedge clock) begin
    bit dReq, iReq, forceI, gD, gI, hit;
    int cnt;
    dReq = (dCmd != 2'd0);
    iReq = (iCmd != 2'd0);
`ifdef MEM_ARB_STARVE_GUARD_EN
    forceI = iReq && (mWait == MEM_ARB_STARVE_LIMIT);
`else
    forceI = 0;
`endif
    gD  = dReq && !forceI;
    gI  = iReq && !gD;
    hit = (memTag != 0) && mValid[memTag];
    cnt = 0;
    for (int t = 0; t < 16; t++) cnt += int'(mValid[t]);
    if (checkEn) begin
      checkOutput("grant_d", 64'(grant_d), 64'(gD));
      checkOutput("cmd", 64'(proc2mem_command), gD ? 64'(dCmd) : gI ? 64'(iCmd) : 64'd0);
      checkOutput("addr", proc2mem_addr, gD ? dAddr : gI ? iAddr : 64'd0);
      checkOutput("data", proc2mem_data, gD ? dData : 64'd0);
      checkOutput("d_resp", 64'(d_mem2proc_response), gD ? 64'(memResp) : 64'd0);
      checkOutput("i_resp", 64'(i_mem2proc_response), gI ? 64'(memResp) : 64'd0);
      checkOutput("d_tag", 64'(d_mem2proc_tag), (hit && mOwnerD[memTag]) ? 64'(memTag) : 64'd0);
      checkOutput("i_tag", 64'(i_mem2proc_tag), (hit && !mOwnerD[memTag]) ? 64'(memTag) : 64'd0);
      checkOutput("d_data", d_mem2proc_data, (hit && mOwnerD[memTag]) ? memData : 64'd0);
      checkOutput("i_data", i_mem2proc_data, (hit && !mOwnerD[memTag]) ? memData : 64'd0);
      checkOutput("count", 64'(outstanding_cnt), 64'(cnt));
      checkOutput("idle", 64'(arb_idle), 64'((cnt == 0) && !dReq && !iReq));
    end
    if (reset) begin
      for (int t = 0; t < 16; t++) mValid[t] = 0;
      mWait = 0;
    end else begin
      if (hit) mValid[memTag] = 0;
      if (((gD && dCmd == 2'd1) || (gI && iCmd == 2'd1)) && memResp != 0) begin
        mValid[memResp]  = 1;
        mOwnerD[memResp] = gD;
      end
      mWait = (iReq && !gI) ? mWait + 1 : 0;
    end
  end

  initial begin
    reset = 1;
    dCmd = 0; dAddr = 0; dData = 0; iCmd = 0; iAddr = 0;
    memResp = 0; memTag = 0; memData = 0;
    repeat (2) @(posedge clock);
    #1;
    reset   = 0;
    checkEn = 1;
    @(negedge clock);
    checkOutput("rst_count", 64'(outstanding_cnt), 64'd0);
    checkOutput("rst_idle", 64'(arb_idle), 64'd1);

    applyStimulus(BUS_LOAD, 64'h1000, 64'h0, BUS_NONE, 64'h0, 4'd3, 4'd0, 64'h0);
    @(negedge clock);
    checkOutput("lit_addr1000", proc2mem_addr, 64'h1000);
    checkOutput("lit_dresp3", 64'(d_mem2proc_response), 64'd3);
    checkOutput("lit_iresp0", 64'(i_mem2proc_response), 64'd0);

    applyStimulus(BUS_NONE, 64'h0, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    checkOutput("lit_count1", 64'(outstanding_cnt), 64'd1);

    applyStimulus(BUS_LOAD, 64'h2000, 64'h0, BUS_LOAD, 64'h40, 4'd5, 4'd0, 64'h0);
    @(negedge clock);
    checkOutput("lit_both_grantd", 64'(grant_d), 64'd1);
    checkOutput("lit_both_iresp", 64'(i_mem2proc_response), 64'd0);

    applyStimulus(BUS_NONE, 64'h0, 64'hFFFF, BUS_LOAD, 64'h40, 4'd6, 4'd0, 64'h0);
    @(negedge clock);
    checkOutput("lit_retry_iresp", 64'(i_mem2proc_response), 64'd6);
    checkOutput("lit_idata_zero", proc2mem_data, 64'd0);
    checkOutput("lit_count2", 64'(outstanding_cnt), 64'd2);

    applyStimulus(BUS_NONE, 64'h0, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd6, 64'hDEADBEEF);
    @(negedge clock);
    checkOutput("lit_ret_itag", 64'(i_mem2proc_tag), 64'd6);
    checkOutput("lit_ret_idata", i_mem2proc_data, 64'hDEADBEEF);
    checkOutput("lit_ret_dtag", 64'(d_mem2proc_tag), 64'd0);

    applyStimulus(BUS_NONE, 64'h0, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    checkOutput("lit_count_after_ret", 64'(outstanding_cnt), 64'd2);

    applyStimulus(BUS_STORE, 64'h3000, 64'h55, BUS_NONE, 64'h0, 4'd7, 4'd0, 64'h0);
    applyStimulus(BUS_NONE, 64'h0, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd7, 64'h77);
    @(negedge clock);
    checkOutput("lit_store_dtag", 64'(d_mem2proc_tag), 64'd0);
    checkOutput("lit_store_itag", 64'(i_mem2proc_tag), 64'd0);
    checkOutput("lit_store_count", 64'(outstanding_cnt), 64'd2);

    applyStimulus(BUS_NONE, 64'h0, 64'h0, BUS_LOAD, 64'h80, 4'd4, 4'd0, 64'h0);
    applyStimulus(BUS_LOAD, 64'h4000, 64'h0, BUS_NONE, 64'h0, 4'd4, 4'd4, 64'h1234);
    @(negedge clock);
    checkOutput("lit_same_itag", 64'(i_mem2proc_tag), 64'd4);
    checkOutput("lit_same_idata", i_mem2proc_data, 64'h1234);
    applyStimulus(BUS_NONE, 64'h0, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd4, 64'hABCD);
    @(negedge clock);
    checkOutput("lit_same_count", 64'(outstanding_cnt), 64'd3);
    checkOutput("lit_same_dtag", 64'(d_mem2proc_tag), 64'd4);
    checkOutput("lit_same_ddata", d_mem2proc_data, 64'hABCD);

    applyStimulus(BUS_NONE, 64'h0, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd3, 64'h33);
    applyStimulus(BUS_NONE, 64'h0, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd5, 64'h55);
    applyStimulus(BUS_NONE, 64'h0, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    checkOutput("lit_drain_count", 64'(outstanding_cnt), 64'd0);
    checkOutput("lit_drain_idle", 64'(arb_idle), 64'd1);

    applyStimulus(BUS_LOAD, 64'h5000, 64'h0, BUS_NONE, 64'h0, 4'd9, 4'd0, 64'h0);
    @(posedge clock);
    #1;
    reset = 1;
    dCmd = 0; memResp = 0;
    @(negedge clock);
    checkOutput("lit_prereset_count", 64'(outstanding_cnt), 64'd1);
    applyStimulus(BUS_NONE, 64'h0, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd9, 64'h99);
    @(negedge clock);
    checkOutput("lit_postreset_dtag", 64'(d_mem2proc_tag), 64'd0);
    checkOutput("lit_postreset_count", 64'(outstanding_cnt), 64'd0);

    for (int k = 0; k < 12; k++) begin
      applyStimulus(BUS_LOAD, 64'h6000, 64'h0, BUS_LOAD, 64'hC0, 4'd0, 4'd0, 64'h0);
      @(negedge clock);
`ifdef MEM_ARB_STARVE_GUARD_EN
      checkOutput("lit_starve_grantd", 64'(grant_d), (k == 8) ? 64'd0 : 64'd1);
`else
      checkOutput("lit_starve_grantd", 64'(grant_d), 64'd1);
`endif
    end

    applyStimulus(BUS_NONE, 64'h0, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    checkEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
